// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the fetch stage.
package imem_loader_pkg;

  localparam int unsigned ADDRESS_WIDTH    = 5;
  localparam int unsigned INSTRUCTION_SIZE = 32;
  localparam int unsigned BYTES_PER_WORD   = 4;
  localparam int unsigned IMEM_AW          = ADDRESS_WIDTH + 1;
  localparam int unsigned DEPTH            = 2 ** IMEM_AW;
  localparam int unsigned WL_W             = ADDRESS_WIDTH + 2;
  localparam int unsigned BCNT_W           = $clog2(BYTES_PER_WORD);

  typedef logic [INSTRUCTION_SIZE-1:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } loader_state_e;

  // States in which a new load session may be started.
  function automatic logic can_start(input loader_state_e st);
    return (st == ST_IDLE) || (st == ST_DONE) || (st == ST_ERR);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_byte_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

interface imem_loader_wr_if;
  import imem_loader_pkg::*;

  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  word_t              imem_wdata;

  modport master (output imem_we, output imem_addr, output imem_wdata);
  modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Collects little-endian bytes into 32-bit words; flags the accept that completes one.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       accept,
  input  logic [7:0] byte_in,
  output logic       word_valid_c,
  output word_t      word_c
);

  logic [BCNT_W-1:0]             byte_cnt;
  logic [INSTRUCTION_SIZE-9:0]   shreg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_cnt <= '0;
      shreg    <= '0;
    end else if (accept) begin
      byte_cnt <= byte_cnt + BCNT_W'(1);
      case (byte_cnt)
        2'd0:    shreg[7:0]   <= byte_in;
        2'd1:    shreg[15:8]  <= byte_in;
        2'd2:    shreg[23:16] <= byte_in;
        default: ;
      endcase
    end
  end

  // The fourth byte goes straight into the top lane so the word is usable this cycle.
  assign word_valid_c = accept && (byte_cnt == BCNT_W'(BYTES_PER_WORD - 1));
  assign word_c       = {byte_in, shreg};

endmodule

// File: rtl/imem_loader.sv
// Loads a checksummed program into instruction memory and holds the core in reset until done.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  imem_loader_byte_if.slave    stream,
  imem_loader_wr_if.master     imem,
  output logic                 cpu_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WL_W-1:0]      words_loaded
);

  loader_state_e   state;
  logic [WL_W-1:0] n_words;
  word_t           checksum;

  logic            accept;
  logic            clear;
  logic            word_valid;
  word_t           word;
  logic [WL_W-1:0] wl_next;

  assign accept  = stream.in_valid && stream.in_ready;
  assign clear   = can_start(state) && start;
  assign wl_next = words_loaded + WL_W'(1);

  imem_loader_byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .accept       (accept),
    .byte_in      (stream.in_data),
    .word_valid_c (word_valid),
    .word_c       (word)
  );

  // Session FSM with registered status, handshake and write-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      stream.in_ready <= 1'b0;
      imem.imem_we    <= 1'b0;
      imem.imem_addr  <= '0;
      imem.imem_wdata <= '0;
      cpu_rst         <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      words_loaded    <= '0;
      n_words         <= '0;
      checksum        <= '0;
    end else begin
      imem.imem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state           <= ST_HDR;
            stream.in_ready <= 1'b1;
            busy            <= 1'b1;
            cpu_rst         <= 1'b1;
            done            <= 1'b0;
            err             <= 1'b0;
            words_loaded    <= '0;
            checksum        <= '0;
          end
        end

        ST_HDR: begin
          if (word_valid) begin
            // Full 32-bit compare so large headers cannot alias into a legal length.
            if (word > INSTRUCTION_SIZE'(DEPTH)) begin
              state           <= ST_ERR;
              stream.in_ready <= 1'b0;
              busy            <= 1'b0;
              err             <= 1'b1;
            end else if (word == '0) begin
              state <= ST_CHK;
            end else begin
              n_words <= WL_W'(word);
              state   <= ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          if (word_valid) begin
            imem.imem_we    <= 1'b1;
            imem.imem_addr  <= IMEM_AW'(words_loaded);
            imem.imem_wdata <= word;
            checksum        <= checksum ^ word;
            words_loaded    <= wl_next;
            if (wl_next == n_words) begin
              state <= ST_CHK;
            end
          end
        end

        ST_CHK: begin
          if (word_valid) begin
            stream.in_ready <= 1'b0;
            busy            <= 1'b0;
            if (word == checksum) begin
              state   <= ST_DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state <= ST_ERR;
              err   <= 1'b1;
            end
          end
        end

        default: begin
          state           <= ST_IDLE;
          stream.in_ready <= 1'b0;
          busy            <= 1'b0;
          cpu_rst         <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader with a program-level reference model.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            cpu_rst;
  logic            busy;
  logic            done;
  logic            err;
  logic [WL_W-1:0] words_loaded;

  int checks   = 0;
  int failures = 0;

  imem_loader_byte_if stream ();
  imem_loader_wr_if   imem ();

  imem_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stream       (stream),
    .imem         (imem),
    .cpu_rst      (cpu_rst),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // Program image and observed writes.
  logic [31:0]        prog [DEPTH];
  logic [IMEM_AW-1:0] wq_addr [$];
  word_t              wq_data [$];
  int                 acc_cnt  = 0;
  bit                 prev_wc  = 1'b0;
  int                 we_bad   = 0;

  // Monitor at negedge: every write must follow, by one cycle, the accept of a word's 4th byte.
  always @(negedge clk) begin
    if (rst) begin
      acc_cnt = 0;
      prev_wc = 1'b0;
    end else begin
      if (imem.imem_we) begin
        wq_addr.push_back(imem.imem_addr);
        wq_data.push_back(imem.imem_wdata);
        if (!prev_wc) we_bad++;
      end
      prev_wc = 1'b0;
      if (start && !busy) begin
        acc_cnt = 0;
      end else if (stream.in_valid && stream.in_ready) begin
        prev_wc = ((acc_cnt % 4) == 3);
        acc_cnt++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_xor(input int n);
    logic [31:0] x = 32'h0;
    for (int i = 0; i < n; i++) x ^= prog[i];
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int g;
    int t;
    g = gaps ? int'($urandom_range(0, 3)) : 0;
    repeat (g) begin
      stream.in_valid = 1'b0;
      stream.in_data  = 8'($urandom);
      step();
    end
    stream.in_valid = 1'b1;
    stream.in_data  = b;
    t = 0;
    while (!stream.in_ready && t < 20) begin
      step();
      t++;
    end
    if (!stream.in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_byte_timeout in_ready=%0b required=1", stream.in_ready);
    end
    step();
    stream.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
  endtask

  task automatic send_stream(input logic [31:0] n, input int nsend, input logic [31:0] chk,
                             input bit send_chk, input bit gaps, input bit poke);
    start = 1'b1;
    step();
    start = 1'b0;
    send_word(n, gaps);
    if (poke) start = 1'b1;
    for (int i = 0; i < nsend; i++) send_word(prog[i], gaps);
    start = 1'b0;
    if (send_chk) send_word(chk, gaps);
    step();
    step();
  endtask

  task automatic test_reset();
    logic [50:0] got;
    logic [50:0] expv;
    rst = 1'b1;
    start = 1'b0;
    stream.in_valid = 1'b0;
    stream.in_data  = 8'h00;
    repeat (3) step();
    rst = 1'b0;
    step();
    got  = {stream.in_ready, imem.imem_we, imem.imem_addr, imem.imem_wdata,
            cpu_rst, busy, done, err, words_loaded};
    expv = {1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0};
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL reset_values got=%h expected=%h", got, expv);
    end
  endtask

  task automatic test_basic(input logic [31:0] chk);
    int wb;
    int bad0;
    bit ok;
    prog[0] = 32'h1; prog[1] = 32'h2; prog[2] = 32'h4;
    ok   = (chk == model_xor(3));
    wb   = wq_addr.size();
    bad0 = we_bad;
    send_stream(32'd3, 3, chk, 1'b1, 1'b0, 1'b1);
    checks++;
    if (wq_addr.size() - wb !== 3) begin
      failures++;
      $display("FAIL basic_write_count got=%0d expected=3", wq_addr.size() - wb);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wq_addr[wb+i] !== IMEM_AW'(i) || wq_data[wb+i] !== prog[i]) begin
          failures++;
          $display("FAIL basic_write%0d got=%0d:%h expected=%0d:%h", i, wq_addr[wb+i],
                   wq_data[wb+i], i, prog[i]);
        end
      end
    end
    checks++;
    if ({done, err, cpu_rst, busy, stream.in_ready} !== {ok, !ok, !ok, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL basic_status done/err/cpu_rst/busy/rdy got=%b expected=%b",
               {done, err, cpu_rst, busy, stream.in_ready}, {ok, !ok, !ok, 1'b0, 1'b0});
    end
    checks++;
    if (words_loaded !== 7'd3 || we_bad !== bad0) begin
      failures++;
      $display("FAIL basic_wl_timing words_loaded=%0d expected=3 bad_we=%0d expected=0",
               words_loaded, we_bad - bad0);
    end
  endtask

  task automatic test_restart();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({cpu_rst, done, err, busy, stream.in_ready, words_loaded} !==
        {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 7'd0}) begin
      failures++;
      $display("FAIL restart_from_done cpu_rst/done/err/busy/rdy=%b wl=%0d expected=10011 wl=0",
               {cpu_rst, done, err, busy, stream.in_ready}, words_loaded);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] hdrs [2];
    int wb;
    hdrs[0] = 32'd65;
    hdrs[1] = 32'h8000_0002;
    for (int h = 0; h < 2; h++) begin
      wb = wq_addr.size();
      start = 1'b1;
      step();
      start = 1'b0;
      send_word(hdrs[h], 1'b0);
      checks++;
      if ({err, done, stream.in_ready, busy, cpu_rst} !== 5'b10001) begin
        failures++;
        $display("FAIL overflow_hdr n=%h err/done/rdy/busy/cpu_rst got=%b expected=10001",
                 hdrs[h], {err, done, stream.in_ready, busy, cpu_rst});
      end
      repeat (3) step();
      checks++;
      if (wq_addr.size() !== wb || err !== 1'b1) begin
        failures++;
        $display("FAIL overflow_nowrite n=%h writes=%0d expected=0 err=%0b", hdrs[h],
                 wq_addr.size() - wb, err);
      end
    end
  endtask

  task automatic test_empty();
    int wb;
    wb = wq_addr.size();
    send_stream(32'd0, 0, 32'd0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({done, err, cpu_rst} !== 3'b100 || wq_addr.size() !== wb || words_loaded !== 7'd0) begin
      failures++;
      $display("FAIL empty_program done/err/cpu_rst=%b expected=100 writes=%0d wl=%0d",
               {done, err, cpu_rst}, wq_addr.size() - wb, words_loaded);
    end
  endtask

  task automatic test_full();
    int wb;
    int mism;
    for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
    wb = wq_addr.size();
    send_stream(32'd64, DEPTH, model_xor(DEPTH), 1'b1, 1'b0, 1'b0);
    checks++;
    if (wq_addr.size() - wb !== DEPTH) begin
      failures++;
      $display("FAIL full_write_count got=%0d expected=64", wq_addr.size() - wb);
    end else begin
      mism = 0;
      for (int i = 0; i < DEPTH; i++)
        if (wq_addr[wb+i] !== IMEM_AW'(i) || wq_data[wb+i] !== prog[i]) mism++;
      checks++;
      if (mism != 0 || wq_addr[wb+DEPTH-1] !== 6'd63) begin
        failures++;
        $display("FAIL full_write_data mismatched=%0d last_addr=%0d expected 0 and 63", mism,
                 wq_addr[wb+DEPTH-1]);
      end
    end
    checks++;
    if ({done, err, cpu_rst} !== 3'b100 || words_loaded !== 7'd64) begin
      failures++;
      $display("FAIL full_status done/err/cpu_rst=%b expected=100 wl=%0d expected=64",
               {done, err, cpu_rst}, words_loaded);
    end
  endtask

  task automatic test_random_valid();
    int wb;
    int bad0;
    prog[0] = 32'h1234_5678;
    wb   = wq_addr.size();
    bad0 = we_bad;
    send_stream(32'd1, 1, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
    checks++;
    if (wq_addr.size() - wb !== 1 || we_bad !== bad0) begin
      failures++;
      $display("FAIL gappy_count writes=%0d expected=1 bad_we=%0d expected=0",
               wq_addr.size() - wb, we_bad - bad0);
    end else begin
      checks++;
      if (wq_data[wb] !== 32'h1234_5678 || wq_addr[wb] !== 6'd0) begin
        failures++;
        $display("FAIL gappy_word got=%0d:%h expected=0:12345678", wq_addr[wb], wq_data[wb]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [50:0] got;
    int wb;
    int mism;
    for (int i = 0; i < 4; i++) prog[i] = $urandom;
    start = 1'b1;
    step();
    start = 1'b0;
    send_word(32'd4, 1'b0);
    send_word(prog[0], 1'b0);
    send_word(prog[1], 1'b0);
    rst = 1'b1;
    step();
    got = {stream.in_ready, imem.imem_we, imem.imem_addr, imem.imem_wdata,
           cpu_rst, busy, done, err, words_loaded};
    checks++;
    if (got !== {1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0}) begin
      failures++;
      $display("FAIL reset_mid_session got=%h expected=%h", got,
               {1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0});
    end
    rst = 1'b0;
    step();
    wb = wq_addr.size();
    send_stream(32'd4, 4, model_xor(4), 1'b1, 1'b1, 1'b0);
    mism = (wq_addr.size() - wb == 4) ? 0 : 100;
    if (mism == 0)
      for (int i = 0; i < 4; i++)
        if (wq_addr[wb+i] !== IMEM_AW'(i) || wq_data[wb+i] !== prog[i]) mism++;
    checks++;
    if (mism != 0 || done !== 1'b1 || words_loaded !== 7'd4) begin
      failures++;
      $display("FAIL reload_after_reset mismatched=%0d done=%0b wl=%0d expected 0,1,4", mism,
               done, words_loaded);
    end
  endtask

  task automatic test_random_programs();
    logic [31:0] n;
    logic [31:0] chk;
    bit ovf;
    bit bad;
    bit ok;
    int nw;
    int wb;
    int bad0;
    int mism;
    for (int it = 0; it < 8; it++) begin
      ovf = ($urandom_range(0, 4) == 0);
      bad = ($urandom_range(0, 2) == 0);
      n   = ovf ? ($urandom | 32'h100) : 32'($urandom_range(0, DEPTH));
      nw  = ovf ? 0 : int'(n);
      for (int i = 0; i < nw; i++) prog[i] = $urandom;
      chk = model_xor(nw) ^ (bad ? (32'h1 << $urandom_range(0, 31)) : 32'h0);
      ok  = !ovf && !bad;
      wb   = wq_addr.size();
      bad0 = we_bad;
      send_stream(n, nw, chk, !ovf, 1'b1, (nw > 0));
      mism = (wq_addr.size() - wb == nw) ? 0 : 1000;
      if (mism == 0)
        for (int i = 0; i < nw; i++)
          if (wq_addr[wb+i] !== IMEM_AW'(i) || wq_data[wb+i] !== prog[i]) mism++;
      checks++;
      if (mism != 0 || we_bad !== bad0) begin
        failures++;
        $display("FAIL random%0d_writes n=%h writes=%0d expected=%0d mismatched=%0d bad_we=%0d",
                 it, n, wq_addr.size() - wb, nw, mism, we_bad - bad0);
      end
      checks++;
      if ({done, err, cpu_rst, busy} !== {ok, !ok, !ok, 1'b0} || words_loaded !== WL_W'(nw)) begin
        failures++;
        $display("FAIL random%0d_status done/err/cpu_rst/busy=%b expected=%b wl=%0d expected=%0d",
                 it, {done, err, cpu_rst, busy}, {ok, !ok, !ok, 1'b0}, words_loaded, nw);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic(32'h7);
    test_restart();
    test_basic(32'h6);
    test_overflow();
    test_empty();
    test_full();
    test_random_valid();
    test_reset_mid();
    test_random_programs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
